// File: rtl/cordic_rotate_ctrl.sv
// ---------------------------------------------------------------------------
// cordic_rotate_ctrl
//   Iterative CORDIC rotation engine for the fixed-point trig path. Takes one
//   signed Q8.24 angle, folds it into [-pi/2, +pi/2] with a quadrant
//   pre-rotation, then runs 24 shift-add micro-rotations (one per clock)
//   against the arctangent ROM and returns registered cos/sin.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     request strobe, only honoured when idle
//   angle_in  signed Q8.24 angle in radians, legal range [-pi, +pi]
//   busy      high while a request is in flight
//   done      one-cycle pulse, results valid from this cycle on
//   err       angle was out of range (outputs forced to 0)
//   cos_out   signed Q8.24 cosine
//   sin_out   signed Q8.24 sine
// ---------------------------------------------------------------------------

// Arctangent constant ROM: atan(2^-step) in Q8.24. For step >= 8 the cubic
// term of the series is below half an LSB, so entries are exact powers of 2.
module fixangles (
    input  logic [4:0]  step,
    output logic [31:0] angle
);
    always_comb begin
        angle = 32'h0000_0000;
        case (step)
            5'd0:    angle = 32'h00C9_0FDB;
            5'd1:    angle = 32'h0076_B19C;
            5'd2:    angle = 32'h003E_B6EC;
            5'd3:    angle = 32'h001F_D5BB;
            5'd4:    angle = 32'h000F_FAAE;
            5'd5:    angle = 32'h0007_FF55;
            5'd6:    angle = 32'h0003_FFEB;
            5'd7:    angle = 32'h0001_FFFD;
            5'd8:    angle = 32'h0001_0000;
            5'd9:    angle = 32'h0000_8000;
            5'd10:   angle = 32'h0000_4000;
            5'd11:   angle = 32'h0000_2000;
            5'd12:   angle = 32'h0000_1000;
            5'd13:   angle = 32'h0000_0800;
            5'd14:   angle = 32'h0000_0400;
            5'd15:   angle = 32'h0000_0200;
            5'd16:   angle = 32'h0000_0100;
            5'd17:   angle = 32'h0000_0080;
            5'd18:   angle = 32'h0000_0040;
            5'd19:   angle = 32'h0000_0020;
            5'd20:   angle = 32'h0000_0010;
            5'd21:   angle = 32'h0000_0008;
            5'd22:   angle = 32'h0000_0004;
            5'd23:   angle = 32'h0000_0002;
            default: angle = 32'h0000_0000;
        endcase
    end
endmodule

module cordic_rotate_ctrl #(
    parameter int          ITER = 24,
    parameter logic [31:0] KINV = 32'h009B74EE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] angle_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] cos_out,
    output logic [31:0] sin_out
);

    localparam logic signed [31:0] PI          = 32'sh0324_3F6A;
    localparam logic signed [31:0] NEG_PI      = 32'shFCDB_C096;
    localparam logic signed [31:0] HALF_PI     = 32'sh0192_1FB5;
    localparam logic signed [31:0] NEG_HALF_PI = 32'shFE6D_E04B;
    localparam logic [4:0]         LAST_STEP   = 5'(ITER - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_ITER, ST_FIN} state_t;

    state_t             state, state_nxt;
    logic signed [31:0] x, y, z;
    logic [4:0]         step;
    logic [31:0]        rom_angle;
    logic signed [31:0] x_sh, y_sh;
    logic               accept;
    logic               out_of_range;

    fixangles u_rom (
        .step  (step),
        .angle (rom_angle)
    );

    assign x_sh         = x >>> step;
    assign y_sh         = y >>> step;
    assign out_of_range = (z > PI) || (z < NEG_PI);

    // The done cycle still belongs to the finishing request, so a start
    // coinciding with the done pulse is dropped rather than accepted.
    assign accept = (state == ST_IDLE) && start && !done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_PRE;
            ST_PRE:  state_nxt = out_of_range ? ST_FIN : ST_ITER;
            ST_ITER: if (step == LAST_STEP) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        z    <= angle_in;
                        x    <= KINV;
                        y    <= '0;
                        step <= '0;
                        err  <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                ST_PRE: begin
                    // Fold quadrants II/III onto the +/-90 degree axis so the
                    // residual angle sits inside CORDIC's convergence range.
                    if (out_of_range) begin
                        err <= 1'b1;
                        x   <= '0;
                        y   <= '0;
                    end else if (z > HALF_PI) begin
                        x <= '0;
                        y <= KINV;
                        z <= z - HALF_PI;
                    end else if (z < NEG_HALF_PI) begin
                        x <= '0;
                        y <= -KINV;
                        z <= z + HALF_PI;
                    end
                end
                ST_ITER: begin
                    // Rotate toward z = 0: positive residual rotates CCW.
                    if (!z[31]) begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - $signed(rom_angle);
                    end else begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + $signed(rom_angle);
                    end
                    step <= (step == LAST_STEP) ? 5'd0 : step + 5'd1;
                end
                ST_FIN: begin
                    cos_out <= x;
                    sin_out <= y;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rotate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cordic_rotate_ctrl
//   Scoreboard bench: each accepted request pushes its expected result
//   (computed with real-valued sin/cos) and the accepting edge; a monitor pops
//   and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_cordic_rotate_ctrl;

    localparam int  PI_Q  = 52707178;       // 32'h03243F6A
    localparam real SCALE = 16777216.0;     // 2^24
    localparam real TOL   = 16.0;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] angle_in;
    logic        busy, done, err;
    logic [31:0] cos_out, sin_out;

    cordic_rotate_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .angle_in (angle_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cos_out  (cos_out),
        .sin_out  (sin_out)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] ang;
        bit          e;
        real         c;
        real         s;
        longint      acc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input bit ok, input string detail);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Reference: legal iff |angle| <= pi; otherwise err with zero outputs.
    task automatic push_exp(input logic [31:0] a, input longint acc);
        exp_t e;
        int   sa;
        real  r;
        sa    = $signed(a);
        r     = $itor(sa) / SCALE;
        e.ang = a;
        e.acc = acc;
        e.e   = (sa > PI_Q) || (sa < -PI_Q);
        e.c   = e.e ? 0.0 : $cos(r) * SCALE;
        e.s   = e.e ? 0.0 : $sin(r) * SCALE;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin : mon
        exp_t   e;
        longint lat;
        real    ac, as_;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1'b0,
                    $sformatf("done with no request outstanding, cos=%h sin=%h", cos_out, sin_out));
            end else begin
                e   = sb.pop_front();
                lat = cyc - e.acc + 1;
                ac  = $itor($signed(cos_out));
                as_ = $itor($signed(sin_out));
                chk("latency", lat == (e.e ? 3 : 27),
                    $sformatf("angle=%h got %0d edges, want %0d", e.ang, lat, e.e ? 3 : 27));
                chk("err", err == e.e,
                    $sformatf("angle=%h got %b, want %b", e.ang, err, e.e));
                if (e.e) begin
                    chk("err_outputs_zero", cos_out == 32'h0 && sin_out == 32'h0,
                        $sformatf("angle=%h got cos=%h sin=%h, want 0/0", e.ang, cos_out, sin_out));
                end else begin
                    chk("cos", (ac - e.c <= TOL) && (e.c - ac <= TOL),
                        $sformatf("angle=%h got %0.0f, want %0.1f +/-16", e.ang, ac, e.c));
                    chk("sin", (as_ - e.s <= TOL) && (e.s - as_ <= TOL),
                        $sformatf("angle=%h got %0.0f, want %0.1f +/-16", e.ang, as_, e.s));
                end
                chk("busy_low_at_done", busy == 1'b0,
                    $sformatf("angle=%h got busy=%b, want 0", e.ang, busy));
            end
        end
    end

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk(name, 1'b0, "no done within 60 cycles, want one");
    endtask

    task automatic run_txn(input logic [31:0] a);
        @(negedge clk);
        angle_in = a;
        start    = 1'b1;
        push_exp(a, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        chk("accept_state", busy == 1'b1 && err == 1'b0 && done == 1'b0,
            $sformatf("angle=%h got busy=%b err=%b done=%b, want 1/0/0", a, busy, err, done));
        wait_done("done_timeout");
    endtask

    function automatic logic [31:0] rand_angle();
        int unsigned r;
        int          sa;
        if ($urandom_range(0, 9) < 8) begin
            r  = $urandom_range(2 * PI_Q, 0);
            sa = int'(r) - PI_Q;
        end else begin
            r  = $urandom_range(32'h0100_0000, 1);
            sa = ($urandom_range(1, 0) == 1) ? PI_Q + int'(r) : -PI_Q - int'(r);
        end
        return sa;
    endfunction

    initial begin : stim
        bit no_done;
        bit busy_ok;
        rst      = 1'b1;
        start    = 1'b0;
        angle_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            busy == 0 && done == 0 && err == 0 && cos_out == 0 && sin_out == 0,
            $sformatf("got busy=%b done=%b err=%b cos=%h sin=%h, want all 0",
                      busy, done, err, cos_out, sin_out));
        rst = 1'b0;

        // Directed points and range boundaries
        run_txn(32'h0000_0000);
        run_txn(32'h0086_0A92);
        run_txn(32'h0324_3F6A);
        run_txn(32'hFE6D_E04B);
        run_txn(32'h0330_0000);
        run_txn(32'h0040_0000);
        run_txn(32'hFCDB_C096);
        run_txn(32'h0324_3F6B);
        run_txn(32'hFCDB_C095);
        run_txn(32'h0192_1FB6);

        // Starts while busy and in the done cycle are dropped
        @(negedge clk);
        angle_in = 32'h00C9_0FDB;
        start    = 1'b1;
        push_exp(angle_in, cyc + 1);
        @(negedge clk);
        start   = 1'b0;
        busy_ok = busy;
        repeat (4) begin
            @(negedge clk);
            busy_ok &= busy;
        end
        angle_in = 32'h0324_3F6A;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            busy_ok &= busy;
            @(negedge clk);
        end
        chk("busy_continuous", busy_ok, $sformatf("got a busy gap, want busy held until done"));
        chk("b2b_done_seen", done == 1'b1, $sformatf("got done=%b, want 1", done));
        angle_in = 32'h0324_3F6A;
        start    = 1'b1;
        @(negedge clk);
        chk("done_cycle_start_ignored", busy == 1'b0,
            $sformatf("got busy=%b, want 0", busy));
        angle_in = 32'hFF00_0000;
        push_exp(angle_in, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        chk("start_after_done_accepted", busy == 1'b1,
            $sformatf("got busy=%b, want 1", busy));
        wait_done("b2b_done_timeout");

        // Reset in the middle of the iterations drops the request
        @(negedge clk);
        angle_in = 32'h0000_0000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_iter_reset",
            busy == 0 && done == 0 && err == 0 && cos_out == 0 && sin_out == 0,
            $sformatf("got busy=%b done=%b err=%b cos=%h sin=%h, want all 0",
                      busy, done, err, cos_out, sin_out));
        rst     = 1'b0;
        no_done = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) no_done = 1'b0;
        end
        chk("no_done_after_reset", no_done, "got done/busy after reset, want neither");
        run_txn(32'h0000_0000);

        // Randomised requests with random idle gaps
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            run_txn(rand_angle());
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size() == 0,
            $sformatf("got %0d outstanding, want 0", sb.size()));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        fails++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
